aead_seq_ctrl: RTL and testbench

AEAD_SEQ_CTRL -- requirements
Module: aead_seq_ctrl

---
 rtl/aead_seq_pkg.sv | 21 ++
 rtl/aead_keep_gen.sv | 35 +++
 rtl/aead_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_aead_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aead_seq_pkg.sv
// aead_seq_pkg
// Shared definitions for the AEAD sequencing controller: FSM state encoding,
// algorithm select codes and the engine beat size in bytes.
package aead_seq_pkg;

  localparam logic ALGO_AES    = 1'b0;
  localparam logic ALGO_CHACHA = 1'b1;

  localparam int BEAT_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG      = 3'd1,
    AAD      = 3'd2,
    PLD      = 3'd3,
    LEN      = 3'd4,
    WAIT_TAG = 3'd5,
    TAG_OUT  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/aead_keep_gen.sv
// aead_keep_gen
// Maps the number of bytes still to be sent in the current phase to the byte
// enable of the beat on the bus and whether that beat is the phase's last.
// Byte 0 of a beat sits in data[127:120], so partial beats fill keep from
// the MSB down.
//   rem_bytes  in  32  bytes remaining in the current phase
//   keep       out 16  byte enables for the current beat
//   last       out 1   current beat is the final beat of the phase
module aead_keep_gen
  import aead_seq_pkg::*;
(
  input  logic [31:0] rem_bytes,
  output logic [15:0] keep,
  output logic        last
);

  logic [4:0] shift_amt;

  // A full beat needs no shift; a partial beat of n bytes keeps the top n bits.
  always_comb begin
    keep      = 16'hFFFF;
    last      = 1'b0;
    shift_amt = 5'd0;
    if (rem_bytes <= 32'(BEAT_BYTES)) begin
      last = 1'b1;
      if (rem_bytes == 32'd0) begin
        keep = 16'h0000;
      end else if (rem_bytes < 32'(BEAT_BYTES)) begin
        shift_amt = 5'd16 - {1'b0, rem_bytes[3:0]};
        keep      = 16'hFFFF << shift_amt;
      end
    end
  end

endmodule

// File: rtl/aead_seq_ctrl.sv
// aead_seq_ctrl
// Sequences one AEAD job through an AES-GCM or ChaCha20-Poly1305 engine:
// configure, stream AAD beats, stream payload beats, issue the lengths block,
// collect the two tag halves and hand the combined tag to the host.
//   clk, rst_n                        clock, async active-low reset
//   job_valid/job_ready, job_*        job descriptor handshake
//   in_valid/in_ready/in_data         host beat stream (AAD then payload)
//   cfg_we, algo_sel                  engine config strobe, held algorithm
//   aad_*/pld_*                       engine AAD and payload ports
//   len_valid/len_block/len_ready     engine lengths port
//   aad_done/pld_done/lens_done       engine pulses (informational only)
//   tag_pre_xor*, tagmask*            engine tag halves
//   tag_valid/tag_ready/tag           final tag handshake
//   busy, err                         job in progress, sticky timeout flag
module aead_seq_ctrl
  import aead_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int DW          = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic          job_algo,
  input  logic [15:0]   job_aad_bytes,
  input  logic [31:0]   job_pld_bytes,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          cfg_we,
  output logic          algo_sel,
  output logic          aad_valid,
  output logic [DW-1:0] aad_data,
  output logic [15:0]   aad_keep,
  input  logic          aad_ready,
  output logic          pld_valid,
  output logic [DW-1:0] pld_data,
  output logic [15:0]   pld_keep,
  input  logic          pld_ready,
  output logic          len_valid,
  output logic [127:0]  len_block,
  input  logic          len_ready,
  input  logic          aad_done,
  input  logic          pld_done,
  input  logic          lens_done,
  input  logic [127:0]  tag_pre_xor,
  input  logic          tag_pre_xor_valid,
  input  logic [127:0]  tagmask,
  input  logic          tagmask_valid,
  output logic          tag_valid,
  input  logic          tag_ready,
  output logic [127:0]  tag,
  output logic          busy,
  output logic          err
);

  if (DW != 128) begin : g_dw_check
    $error("aead_seq_ctrl: DW must be 128");
  end

  seq_state_t   state, state_next;
  logic [15:0]  aad_bytes_q;
  logic [31:0]  pld_bytes_q;
  logic [31:0]  rem_bytes;
  logic [31:0]  tmo_cnt;
  logic [127:0] pre_q, mask_q;
  logic         have_pre, have_mask;
  logic [15:0]  beat_keep;
  logic         beat_last;
  logic         beat_fire;
  logic         timeout_fire;
  logic [63:0]  len_aad, len_pld;
  logic         unused_done;

  // The engine's phase-complete pulses never steer the sequencer.
  assign unused_done = aad_done | pld_done | lens_done;

  aead_keep_gen u_keep_gen (
    .rem_bytes (rem_bytes),
    .keep      (beat_keep),
    .last      (beat_last)
  );

  // A ChaCha length field is the byte count laid out little-endian.
  function automatic logic [63:0] le64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*(7-i) +: 8] = v[8*i +: 8];
    end
    return r;
  endfunction

  // AES-GCM wants bit lengths big-endian; ChaCha-Poly wants byte lengths LE.
  always_comb begin
    if (algo_sel == ALGO_AES) begin
      len_aad = {45'd0, aad_bytes_q, 3'b000};
      len_pld = {29'd0, pld_bytes_q, 3'b000};
    end else begin
      len_aad = le64({48'd0, aad_bytes_q});
      len_pld = le64({32'd0, pld_bytes_q});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all handshake outputs; the data ports are zeroed outside
  // their phase so nothing leaks onto an idle engine port.
  always_comb begin
    state_next   = state;
    job_ready    = 1'b0;
    busy         = 1'b1;
    cfg_we       = 1'b0;
    in_ready     = 1'b0;
    aad_valid    = 1'b0;
    aad_data     = '0;
    aad_keep     = 16'h0000;
    pld_valid    = 1'b0;
    pld_data     = '0;
    pld_keep     = 16'h0000;
    len_valid    = 1'b0;
    len_block    = '0;
    tag_valid    = 1'b0;
    tag          = '0;
    beat_fire    = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        job_ready = 1'b1;
        if (job_valid) state_next = CFG;
      end
      CFG: begin
        cfg_we = 1'b1;
        if (aad_bytes_q != 16'd0)      state_next = AAD;
        else if (pld_bytes_q != 32'd0) state_next = PLD;
        else                           state_next = LEN;
      end
      AAD: begin
        aad_valid = in_valid;
        aad_data  = in_data;
        aad_keep  = beat_keep;
        in_ready  = aad_ready;
        beat_fire = in_valid & aad_ready;
        if (beat_fire && beat_last) begin
          state_next = (pld_bytes_q != 32'd0) ? PLD : LEN;
        end
      end
      PLD: begin
        pld_valid = in_valid;
        pld_data  = in_data;
        pld_keep  = beat_keep;
        in_ready  = pld_ready;
        beat_fire = in_valid & pld_ready;
        if (beat_fire && beat_last) state_next = LEN;
      end
      LEN: begin
        len_valid = 1'b1;
        len_block = {len_aad, len_pld};
        if (len_ready) state_next = WAIT_TAG;
      end
      WAIT_TAG: begin
        if (have_pre && have_mask) begin
          state_next = TAG_OUT;
        end else if (tmo_cnt == 32'(TIMEOUT_CYC - 1)) begin
          timeout_fire = 1'b1;
          state_next   = IDLE;
        end
      end
      TAG_OUT: begin
        tag_valid = 1'b1;
        tag       = pre_q ^ mask_q;
        if (tag_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Descriptor, byte counter, timeout counter and tag-half capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      algo_sel    <= 1'b0;
      aad_bytes_q <= 16'd0;
      pld_bytes_q <= 32'd0;
      rem_bytes   <= 32'd0;
      tmo_cnt     <= 32'd0;
      pre_q       <= '0;
      mask_q      <= '0;
      have_pre    <= 1'b0;
      have_mask   <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            algo_sel    <= job_algo;
            aad_bytes_q <= job_aad_bytes;
            pld_bytes_q <= job_pld_bytes;
            pre_q       <= '0;
            mask_q      <= '0;
            have_pre    <= 1'b0;
            have_mask   <= 1'b0;
            err         <= 1'b0;
          end
        end
        CFG: begin
          rem_bytes <= (aad_bytes_q != 16'd0) ? {16'd0, aad_bytes_q} : pld_bytes_q;
        end
        AAD, PLD: begin
          if (beat_fire) begin
            if (state == AAD && beat_last) begin
              rem_bytes <= pld_bytes_q;
            end else if (rem_bytes > 32'(BEAT_BYTES)) begin
              rem_bytes <= rem_bytes - 32'(BEAT_BYTES);
            end else begin
              rem_bytes <= 32'd0;
            end
          end
        end
        WAIT_TAG: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tag_pre_xor_valid) begin
            pre_q    <= tag_pre_xor;
            have_pre <= 1'b1;
          end
          if (tagmask_valid) begin
            mask_q    <= tagmask;
            have_mask <= 1'b1;
          end
          if (timeout_fire) err <= 1'b1;
        end
        default: ;
      endcase
      if (state != WAIT_TAG) tmo_cnt <= 32'd0;
    end
  end

endmodule

// File: tb/tb_aead_seq_ctrl.sv
// tb_aead_seq_ctrl
// Self-checking bench: directed jobs for the documented scenarios plus
// randomized jobs, each compared against a beat/length/tag reference model.
module tb_aead_seq_ctrl;

  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         job_valid, job_ready, job_algo;
  logic [15:0]  job_aad_bytes;
  logic [31:0]  job_pld_bytes;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         cfg_we, algo_sel;
  logic         aad_valid, aad_ready, pld_valid, pld_ready;
  logic [127:0] aad_data, pld_data;
  logic [15:0]  aad_keep, pld_keep;
  logic         len_valid, len_ready;
  logic [127:0] len_block;
  logic         aad_done, pld_done, lens_done;
  logic [127:0] tag_pre_xor, tagmask, tag;
  logic         tag_pre_xor_valid, tagmask_valid;
  logic         tag_valid, tag_ready;
  logic         busy, err;

  int total = 0;
  int bad   = 0;
  logic err_model = 1'b0;

  always #5 clk = ~clk;

  aead_seq_ctrl #(.TIMEOUT_CYC(TMO), .DW(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_algo(job_algo),
    .job_aad_bytes(job_aad_bytes), .job_pld_bytes(job_pld_bytes),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .algo_sel(algo_sel),
    .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
    .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
    .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done),
    .tag_pre_xor(tag_pre_xor), .tag_pre_xor_valid(tag_pre_xor_valid),
    .tagmask(tagmask), .tagmask_valid(tagmask_valid),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag),
    .busy(busy), .err(err)
  );

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference model: byte enables written out byte by byte from the count.
  function automatic logic [15:0] keep_of(input int rem);
    logic [15:0] k;
    k = 16'h0000;
    if (rem >= 16) return 16'hFFFF;
    for (int b = 0; b < rem; b++) k[15-b] = 1'b1;
    return k;
  endfunction

  function automatic logic [63:0] le64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [127:0] len_of(input logic algo, input logic [15:0] a, input logic [31:0] p);
    logic [63:0] av, pv;
    if (algo == 1'b0) begin
      av = 64'(a) * 64'd8;
      pv = 64'(p) * 64'd8;
    end else begin
      av = le64(64'(a));
      pv = le64(64'(p));
    end
    return {av, pv};
  endfunction

  task automatic check_idle_outputs(input string pfx);
    checkOutput({pfx, "_job_ready"}, 128'(job_ready), 128'(1'b1));
    checkOutput({pfx, "_busy"},      128'(busy), 128'(1'b0));
    checkOutput({pfx, "_cfg_we"},    128'(cfg_we), 128'(1'b0));
    checkOutput({pfx, "_in_ready"},  128'(in_ready), 128'(1'b0));
    checkOutput({pfx, "_aad_valid"}, 128'(aad_valid), 128'(1'b0));
    checkOutput({pfx, "_pld_valid"}, 128'(pld_valid), 128'(1'b0));
    checkOutput({pfx, "_pld_data"},  pld_data, 128'd0);
    checkOutput({pfx, "_pld_keep"},  128'(pld_keep), 128'd0);
    checkOutput({pfx, "_len_valid"}, 128'(len_valid), 128'(1'b0));
    checkOutput({pfx, "_tag_valid"}, 128'(tag_valid), 128'(1'b0));
    checkOutput({pfx, "_algo_sel"},  128'(algo_sel), 128'(1'b0));
    checkOutput({pfx, "_err"},       128'(err), 128'(1'b0));
  endtask

  // mode 0: normal job, 1: withhold tag halves (timeout), 2: reset mid-PLD beat.
  task automatic applyStimulus(input logic algo, input logic [15:0] aad, input logic [31:0] pld,
                               input int mode, input int dm, input int dp, input int hold,
                               input logic [127:0] pre, input logic [127:0] mask);
    logic [15:0] kq[$];
    bit          pq[$];
    int          idx, cyc, n, lim;
    logic        rdy;
    bit          done;
    for (int r = int'(aad); r > 0; r -= 16) begin kq.push_back(keep_of(r)); pq.push_back(1'b0); end
    for (int r = int'(pld); r > 0; r -= 16) begin kq.push_back(keep_of(r)); pq.push_back(1'b1); end

    @(negedge clk);
    #1;
    checkOutput("idle_job_ready", 128'(job_ready), 128'(1'b1));
    checkOutput("idle_err", 128'(err), 128'(err_model));
    job_valid = 1'b1; job_algo = algo; job_aad_bytes = aad; job_pld_bytes = pld;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    err_model = 1'b0;
    #1;
    checkOutput("cfg_we", 128'(cfg_we), 128'(1'b1));
    checkOutput("cfg_busy", 128'(busy), 128'(1'b1));
    checkOutput("cfg_algo_sel", 128'(algo_sel), 128'(algo));
    checkOutput("cfg_err_clr", 128'(err), 128'(1'b0));
    checkOutput("cfg_in_ready", 128'(in_ready), 128'(1'b0));

    idx = 0; cyc = 0;
    while (idx < kq.size() && cyc < 400) begin
      @(negedge clk);
      aad_ready = ($urandom_range(0, 9) < 7);
      pld_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (cyc == 0) checkOutput("cfg_we_single", 128'(cfg_we), 128'(1'b0));
      if (mode == 2 && pq[idx] && in_valid) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        err_model = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check_idle_outputs("rst_rel");
        return;
      end
      if (!pq[idx]) begin
        checkOutput("aad_valid", 128'(aad_valid), 128'(in_valid));
        checkOutput("aad_data",  aad_data, in_data);
        checkOutput("aad_keep",  128'(aad_keep), 128'(kq[idx]));
        checkOutput("aad_pld_valid", 128'(pld_valid), 128'(1'b0));
        checkOutput("aad_in_ready", 128'(in_ready), 128'(aad_ready));
        rdy = aad_ready;
      end else begin
        checkOutput("pld_valid", 128'(pld_valid), 128'(in_valid));
        checkOutput("pld_data",  pld_data, in_data);
        checkOutput("pld_keep",  128'(pld_keep), 128'(kq[idx]));
        checkOutput("pld_aad_valid", 128'(aad_valid), 128'(1'b0));
        checkOutput("pld_in_ready", 128'(in_ready), 128'(pld_ready));
        rdy = pld_ready;
      end
      @(posedge clk);
      if (in_valid && rdy) idx++;
      cyc++;
    end
    if (idx < kq.size()) begin
      checkOutput("beat_budget", 128'(idx), 128'(kq.size()));
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;

    done = 1'b0; cyc = 0;
    while (!done && cyc < 50) begin
      if (cyc > 0) @(negedge clk);
      len_ready = $urandom_range(0, 1);
      #1;
      checkOutput("len_valid", 128'(len_valid), 128'(1'b1));
      checkOutput("len_block", len_block, len_of(algo, aad, pld));
      checkOutput("len_in_ready", 128'(in_ready), 128'(1'b0));
      @(posedge clk);
      done = len_ready;
      cyc++;
    end
    if (!done) begin
      checkOutput("len_budget", 128'(done), 128'(1'b1));
      return;
    end
    @(negedge clk);
    len_ready = 1'b0;

    if (mode == 1) begin
      n = 0;
      #1;
      while (!err && n < TMO + 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput("tmo_window", 128'((n >= TMO - 1) && (n <= TMO + 1)), 128'(1'b1));
      checkOutput("tmo_err", 128'(err), 128'(1'b1));
      checkOutput("tmo_busy", 128'(busy), 128'(1'b0));
      checkOutput("tmo_job_ready", 128'(job_ready), 128'(1'b1));
      checkOutput("tmo_tag_valid", 128'(tag_valid), 128'(1'b0));
      err_model = 1'b1;
      return;
    end

    lim = ((dm > dp) ? dm : dp);
    n = 0;
    while (n <= lim + 10) begin
      if (n > 0) @(negedge clk);
      tag_pre_xor_valid = (n == dp);
      tagmask_valid     = (n == dm);
      tag_pre_xor = (n == dp) ? pre  : {$urandom, $urandom, $urandom, $urandom};
      tagmask     = (n == dm) ? mask : {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (tag_valid) break;
      n++;
    end
    tag_pre_xor_valid = 1'b0;
    tagmask_valid = 1'b0;
    if (!tag_valid) begin
      checkOutput("tag_budget", 128'(tag_valid), 128'(1'b1));
      return;
    end
    checkOutput("tag_not_early", 128'(n > lim), 128'(1'b1));
    tag_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      checkOutput("tag_hold_valid", 128'(tag_valid), 128'(1'b1));
      checkOutput("tag_hold_value", tag, pre ^ mask);
      @(negedge clk);
      #1;
    end
    tag_ready = 1'b1;
    checkOutput("tag_valid", 128'(tag_valid), 128'(1'b1));
    checkOutput("tag_value", tag, pre ^ mask);
    @(posedge clk);
    @(negedge clk);
    tag_ready = 1'b0;
    #1;
    checkOutput("tag_done_valid", 128'(tag_valid), 128'(1'b0));
    checkOutput("tag_done_idle", 128'(job_ready), 128'(1'b1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b0;
    job_valid = 1'b0; job_algo = 1'b0; job_aad_bytes = '0; job_pld_bytes = '0;
    in_valid = 1'b0; in_data = '0; aad_ready = 1'b0; pld_ready = 1'b0; len_ready = 1'b0;
    aad_done = 1'b0; pld_done = 1'b0; lens_done = 1'b0;
    tag_pre_xor = '0; tagmask = '0; tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
    tag_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    checkOutput("reset_len_block", len_block, 128'd0);
    checkOutput("reset_tag", tag, 128'd0);
    rst_n = 1'b1;

    $display("[TB] directed jobs");
    applyStimulus(1'b0, 16'd20, 32'd32, 0, 1, 0, 2, rnd128(), rnd128());
    applyStimulus(1'b1, 16'd0, 32'd5, 0, 0, 2, 1, rnd128(), rnd128());
    applyStimulus(1'b0, 16'd0, 32'd0, 0, 0, 0, 0, {128{1'b1}}, {16{8'h0F}});
    applyStimulus(1'b1, 16'd33, 32'd17, 0, 0, 3, 5, rnd128(), rnd128());
    applyStimulus(1'b0, 16'd4, 32'd8, 1, 0, 0, 0, '0, '0);
    applyStimulus(1'b1, 16'd16, 32'd16, 0, 1, 1, 1, rnd128(), rnd128());
    applyStimulus(1'b0, 16'd16, 32'd40, 2, 0, 0, 0, '0, '0);
    applyStimulus(1'b0, 16'd7, 32'd40, 0, 2, 0, 0, rnd128(), rnd128());

    $display("[TB] random jobs");
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 70)),
                    32'($urandom_range(0, 100)), 0,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), rnd128(), rnd128());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
